// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serializer (start, 8 data LSB first, optional parity, stop).
// Frames from queued bytes go out back-to-back; TX, tx_busy and tx_done are registered.
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_drop
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [12:0]   BAUD_LAST = 13'(BAUD_DIV - 1);
  localparam logic [3:0]    BIT_LAST  = (PARITY == 0) ? 4'd9 : 4'd10;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, XMIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [10:0]   shift_q, shift_d;
  logic [12:0]   baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          drop_q, drop_d;

  logic          pop;
  logic          push_ok;
  logic          bit_adv;
  logic [7:0]    head;
  logic [10:0]   frame_load;

  // Build the frame for the FIFO head; with no parity the unused top bit is an extra 1.
  always_comb begin
    head = mem_q[rd_ptr_q];
    if (PARITY == 0)      frame_load = {2'b11, head, 1'b0};
    else if (PARITY == 1) frame_load = {1'b1, ^head, head, 1'b0};
    else                  frame_load = {1'b1, ~^head, head, 1'b0};
  end

  // Serializer next-state: bit timing, shifting, pop/reload at frame boundaries.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    pop        = 1'b0;
    bit_adv    = (baud_cnt_q == BAUD_LAST);
    done_d     = 1'b0;
    busy_d     = (state_q == XMIT);
    tx_d       = (state_q == XMIT) ? shift_q[0] : 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop        = 1'b1;
          shift_d    = frame_load;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = XMIT;
        end
      end
      XMIT: begin
        if (bit_adv) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            done_d = 1'b1;
            if (!empty_q) begin
              pop       = 1'b1;
              shift_d   = frame_load;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d   = {1'b1, shift_q[10:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 13'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serializer state and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // FIFO bookkeeping; a push into a full FIFO is only allowed when a pop frees a slot the same cycle.
  always_comb begin
    push_ok  = trmt && (!full_q || pop);
    drop_d   = trmt && full_q && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
  end

  // FIFO pointers, count and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage; the head is read before a same-edge write can reuse its slot.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= tx_data;
  end

  assign TX       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx_full  = full_q;
  assign tx_empty = empty_q;
  assign tx_drop  = drop_q;

endmodule
